// File: rtl/mt_pkg.sv
// Shared types and helpers for the barrel-processor thread scheduler.
package mt_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READY    = 2'd1,
        INFLIGHT = 2'd2,
        HALTED   = 2'd3
    } thread_state_t;

    localparam int unsigned PC_CALC_W = 64;

    // Thread-id width; a single thread still needs one bit.
    function automatic int unsigned tid_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w == 0) ? 1 : w;
    endfunction

    // Reset PC of thread t, computed wide; the caller truncates to its PC width.
    function automatic logic [PC_CALC_W-1:0] thread_reset_pc(
        input logic [PC_CALC_W-1:0] base,
        input logic [PC_CALC_W-1:0] stride,
        input int unsigned          t
    );
        return base + stride * PC_CALC_W'(t);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after base, wrapping modulo N.
module rr_arbiter
    import mt_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]             req,
    input  logic [tid_width(N)-1:0]  base,
    output logic                     gnt_valid,
    output logic [tid_width(N)-1:0]  gnt_idx
);

    localparam int unsigned TW = tid_width(N);

    int unsigned idx;

    // Scan from the farthest offset down so the nearest request to base wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned i = N; i > 0; i--) begin
            idx = 32'(base) + i - 32'd1;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[TW'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = TW'(idx);
            end
        end
    end

endmodule

// File: rtl/barrel_thread_sched.sv
// Round-robin thread scheduler and per-thread PC file for the mt_cpu barrel front end.
module barrel_thread_sched
    import mt_pkg::*;
#(
    parameter int unsigned              NUM_THREADS   = 4,
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(32'h0000_0000),
    parameter logic [ADDRESS_WIDTH-1:0] PC_STRIDE     = ADDRESS_WIDTH'(32'h0000_1000),
    parameter int unsigned              TID_W         = tid_width(NUM_THREADS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_THREADS-1:0]   thread_run,
    input  logic                     stall,
    input  logic                     wb_valid,
    input  logic [TID_W-1:0]         wb_tid,
    input  logic [ADDRESS_WIDTH-1:0] wb_pc,
    input  logic                     wb_halt,
    output logic                     issue_valid,
    output logic [TID_W-1:0]         issue_tid,
    output logic [ADDRESS_WIDTH-1:0] issue_pc,
    output logic [NUM_THREADS-1:0]   active,
    output logic                     wb_err
);

    thread_state_t            state_q [NUM_THREADS];
    thread_state_t            state_d [NUM_THREADS];
    logic [ADDRESS_WIDTH-1:0] pc_q    [NUM_THREADS];
    logic [ADDRESS_WIDTH-1:0] pc_d    [NUM_THREADS];
    logic [TID_W-1:0]         last_tid_q;

    logic [NUM_THREADS-1:0]   req;
    logic [NUM_THREADS-1:0]   wb_hit;
    logic [TID_W-1:0]         base;
    logic                     gnt_valid;
    logic [TID_W-1:0]         gnt_idx;
    logic                     do_issue;
    logic                     wb_bad;

    // Eligibility and the active flags come straight from registered state.
    always_comb begin
        req    = '0;
        active = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            req[t]    = (state_q[t] == READY);
            active[t] = (state_q[t] == READY) || (state_q[t] == INFLIGHT);
        end
    end

    assign base = (last_tid_q == TID_W'(NUM_THREADS - 1)) ? '0 : last_tid_q + TID_W'(1);

    rr_arbiter #(.N(NUM_THREADS)) u_arb (
        .req       (req),
        .base      (base),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // A granted thread whose run enable dropped is de-scheduled instead of issued.
    assign do_issue = !stall && gnt_valid && thread_run[gnt_idx];

    // Per-thread next state, PC writeback and writeback error detection.
    always_comb begin
        wb_hit = '0;
        wb_bad = 1'b0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            state_d[t] = state_q[t];
            pc_d[t]    = pc_q[t];
            wb_hit[t]  = wb_valid && (wb_tid == TID_W'(t)) && (state_q[t] == INFLIGHT);
            case (state_q[t])
                IDLE: begin
                    if (thread_run[t]) state_d[t] = READY;
                end
                READY: begin
                    if (do_issue && (gnt_idx == TID_W'(t))) state_d[t] = INFLIGHT;
                    else if (!thread_run[t])                 state_d[t] = IDLE;
                end
                INFLIGHT: begin
                    if (wb_hit[t]) begin
                        state_d[t] = wb_halt ? HALTED : READY;
                        pc_d[t]    = wb_pc;
                    end
                end
                HALTED: begin
                    if (!thread_run[t]) state_d[t] = IDLE;
                end
                default: state_d[t] = IDLE;
            endcase
        end
        wb_bad = wb_valid && !(|wb_hit);
    end

    // State/PC registers, issue registers and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                state_q[t] <= IDLE;
                pc_q[t]    <= ADDRESS_WIDTH'(thread_reset_pc(PC_CALC_W'(RESET_PC),
                                                             PC_CALC_W'(PC_STRIDE), t));
            end
            last_tid_q  <= TID_W'(NUM_THREADS - 1);
            issue_valid <= 1'b0;
            issue_tid   <= '0;
            issue_pc    <= '0;
            wb_err      <= 1'b0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                state_q[t] <= state_d[t];
                pc_q[t]    <= pc_d[t];
            end
            if (!stall) begin
                issue_valid <= do_issue;
                if (do_issue) begin
                    issue_tid  <= gnt_idx;
                    issue_pc   <= pc_q[gnt_idx];
                    last_tid_q <= gnt_idx;
                end
            end
            if (wb_bad) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_barrel_thread_sched.sv
// Directed and randomized checks of barrel_thread_sched against a behavioural thread model.
module tb_barrel_thread_sched;

    localparam int N = 4;
    localparam int S_IDLE = 0, S_READY = 1, S_INFL = 2, S_HALT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  thread_run = '0;
    logic        stall = 1'b0;
    logic        wb_valid = 1'b0;
    logic [1:0]  wb_tid = '0;
    logic [31:0] wb_pc = '0;
    logic        wb_halt = 1'b0;
    logic        issue_valid;
    logic [1:0]  issue_tid;
    logic [31:0] issue_pc;
    logic [3:0]  active;
    logic        wb_err;

    logic [2:0]  run3 = '0;
    logic        wb3_valid = 1'b0;
    logic [1:0]  wb3_tid = '0;
    logic [31:0] wb3_pc = '0;
    logic        iv3;
    logic [1:0]  tid3;
    logic [31:0] pc3;
    logic [2:0]  act3;
    logic        err3;

    int checks = 0;
    int failures = 0;

    // Behavioural model of the scheduler
    int          m_st [N];
    logic [31:0] m_pc [N];
    int          m_last;
    logic        m_iv;
    int          m_itid;
    logic [31:0] m_ipc;
    logic        m_err;

    int          seq [$];
    logic [31:0] pcs [$];
    int          seq3 [$];
    logic        halt_arm = 1'b0;

    always #5 clk = ~clk;

    barrel_thread_sched u_dut (
        .clk(clk), .rst(rst), .thread_run(thread_run), .stall(stall),
        .wb_valid(wb_valid), .wb_tid(wb_tid), .wb_pc(wb_pc), .wb_halt(wb_halt),
        .issue_valid(issue_valid), .issue_tid(issue_tid), .issue_pc(issue_pc),
        .active(active), .wb_err(wb_err)
    );

    barrel_thread_sched #(.NUM_THREADS(3)) u_dut3 (
        .clk(clk), .rst(rst), .thread_run(run3), .stall(1'b0),
        .wb_valid(wb3_valid), .wb_tid(wb3_tid), .wb_pc(wb3_pc), .wb_halt(1'b0),
        .issue_valid(iv3), .issue_tid(tid3), .issue_pc(pc3),
        .active(act3), .wb_err(err3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the model, from the inputs currently applied.
    task automatic model_step();
        int nst [N];
        int pick;
        int c;
        if (!rst) begin
            for (int t = 0; t < N; t++) begin
                m_st[t] = S_IDLE;
                m_pc[t] = 32'h1000 * t;
            end
            m_last = N - 1; m_iv = 0; m_itid = 0; m_ipc = 0; m_err = 0;
            return;
        end
        pick = -1;
        for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (pick < 0 && m_st[c] == S_READY) pick = c;
        end
        if (!stall) begin
            if (pick >= 0 && thread_run[pick]) begin
                m_iv = 1; m_itid = pick; m_ipc = m_pc[pick]; m_last = pick;
            end else begin
                m_iv = 0;
            end
        end
        for (int t = 0; t < N; t++) begin
            nst[t] = m_st[t];
            if (m_st[t] == S_IDLE && thread_run[t]) nst[t] = S_READY;
            if (m_st[t] == S_READY) begin
                if (!stall && pick == t && thread_run[t]) nst[t] = S_INFL;
                else if (!thread_run[t])                  nst[t] = S_IDLE;
            end
            if (m_st[t] == S_HALT && !thread_run[t]) nst[t] = S_IDLE;
        end
        if (wb_valid) begin
            if (m_st[wb_tid] == S_INFL) begin
                nst[wb_tid]  = wb_halt ? S_HALT : S_READY;
                m_pc[wb_tid] = wb_pc;
            end else begin
                m_err = 1;
            end
        end
        for (int t = 0; t < N; t++) m_st[t] = nst[t];
    endtask

    task automatic tick();
        logic [3:0] ea;
        model_step();
        @(posedge clk);
        #1;
        ea = '0;
        for (int t = 0; t < N; t++) ea[t] = (m_st[t] == S_READY) || (m_st[t] == S_INFL);
        chk("issue_valid", 64'(issue_valid), 64'(m_iv));
        chk("issue_tid", 64'(issue_tid), 64'(m_itid));
        chk("issue_pc", 64'(issue_pc), 64'(m_ipc));
        chk("wb_err", 64'(wb_err), 64'(m_err));
        chk("active", 64'(active), 64'(ea));
    endtask

    // Each cycle write back the previous cycle's issue with pc+4.
    task automatic pipe(input int n);
        for (int i = 0; i < n; i++) begin
            wb_valid = issue_valid;
            wb_tid   = issue_tid;
            wb_pc    = issue_pc + 32'd4;
            wb_halt  = 1'b0;
            if (halt_arm && issue_valid && issue_tid == 2'd1) begin
                wb_halt  = 1'b1;
                wb_pc    = 32'h1040;
                halt_arm = 1'b0;
            end
            tick();
            if (issue_valid) begin
                seq.push_back(int'(issue_tid));
                pcs.push_back(issue_pc);
            end
        end
        wb_valid = 1'b0;
        wb_halt  = 1'b0;
    endtask

    initial begin
        int          cnt;
        int          found;
        logic        snap_v;
        logic [1:0]  snap_t;
        logic [31:0] snap_p;
        int          cand [$];

        // Reset values
        rst = 1'b0;
        tick(); tick();
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_active", 64'(active), 64'd0);
        chk("rst_wb_err", 64'(wb_err), 64'd0);
        rst = 1'b1;

        // Single thread: issue two edges after run rises
        thread_run = 4'b0001;
        tick();
        chk("lat_edge1_valid", 64'(issue_valid), 64'd0);
        tick();
        chk("lat_edge2_valid", 64'(issue_valid), 64'd1);
        chk("lat_edge2_tid", 64'(issue_tid), 64'd0);
        chk("lat_edge2_pc", 64'(issue_pc), 64'd0);

        // All threads: rotation 1,2,3,0,...
        thread_run = 4'b1111;
        seq.delete(); pcs.delete();
        pipe(12);
        chk("rr_all_len", 64'(seq.size() >= 10), 64'd1);
        for (int i = 0; i < 10; i++)
            if (i < seq.size()) chk("rr_all_order", 64'(seq[i]), 64'((i + 1) % 4));
        if (seq.size() > 5) chk("rr_t2_second_pc", 64'(pcs[5]), 64'h2004);

        // Odd threads only alternate
        thread_run = 4'b1010;
        pipe(4);
        seq.delete(); pcs.delete();
        pipe(8);
        chk("rr1010_len", 64'(seq.size()), 64'd8);
        for (int i = 0; i < seq.size(); i++) begin
            chk("rr1010_odd", 64'(seq[i] % 2), 64'd1);
            if (i > 0) chk("rr1010_alt", 64'(seq[i] != seq[i-1]), 64'd1);
        end

        // Halt thread 1, confirm it is skipped, then resume from held PC
        thread_run = 4'b1111;
        pipe(4);
        halt_arm = 1'b1;
        pipe(6);
        chk("halt_active1", 64'(active[1]), 64'd0);
        seq.delete(); pcs.delete();
        pipe(8);
        cnt = 0;
        foreach (seq[i]) if (seq[i] == 1) cnt++;
        chk("halt_skip", 64'(cnt), 64'd0);
        chk("halt_rate", 64'(seq.size()), 64'd8);
        thread_run = 4'b1101;
        pipe(1);
        thread_run = 4'b1111;
        seq.delete(); pcs.delete();
        pipe(6);
        found = -1;
        foreach (seq[i]) if (found < 0 && seq[i] == 1) found = i;
        chk("resume_found", 64'(found >= 0), 64'd1);
        if (found >= 0) chk("resume_pc", 64'(pcs[found]), 64'h1040);

        // Stall for three cycles while the outstanding writeback lands
        pipe(3);
        snap_v = issue_valid; snap_t = issue_tid; snap_p = issue_pc;
        stall = 1'b1;
        wb_valid = 1'b1; wb_tid = snap_t; wb_pc = snap_p + 32'd4;
        tick();
        wb_valid = 1'b0;
        tick(); tick();
        chk("stall_hold_valid", 64'(issue_valid), 64'(snap_v));
        chk("stall_hold_tid", 64'(issue_tid), 64'(snap_t));
        chk("stall_hold_pc", 64'(issue_pc), 64'(snap_p));
        stall = 1'b0;
        tick();
        chk("stall_resume_valid", 64'(issue_valid), 64'd1);
        chk("stall_resume_tid", 64'(issue_tid), 64'(snap_t + 2'd1));

        // Drain, then write back to an idle thread
        thread_run = 4'b0000;
        pipe(6);
        chk("drain_active", 64'(active), 64'd0);
        wb_valid = 1'b1; wb_tid = 2'd2; wb_pc = 32'hdead_0000;
        tick();
        wb_valid = 1'b0;
        chk("wb_err_set", 64'(wb_err), 64'd1);
        tick(); tick();
        chk("wb_err_sticky", 64'(wb_err), 64'd1);

        // Reset mid-run with a writeback presented
        thread_run = 4'b1111;
        pipe(5);
        rst = 1'b0;
        wb_valid = 1'b1; wb_tid = issue_tid; wb_pc = 32'h5555_0000;
        tick();
        wb_valid = 1'b0;
        chk("midrst_valid", 64'(issue_valid), 64'd0);
        chk("midrst_tid", 64'(issue_tid), 64'd0);
        chk("midrst_pc", 64'(issue_pc), 64'd0);
        chk("midrst_err", 64'(wb_err), 64'd0);
        chk("midrst_active", 64'(active), 64'd0);
        rst = 1'b1;

        // Randomized traffic with legal writebacks
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) thread_run[$urandom_range(0, 3)] ^= 1'b1;
            cand.delete();
            for (int t = 0; t < N; t++) if (m_st[t] == S_INFL) cand.push_back(t);
            wb_valid = 1'b0; wb_halt = 1'b0;
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                wb_valid = 1'b1;
                wb_tid   = 2'(cand[$urandom_range(0, cand.size() - 1)]);
                wb_pc    = {$urandom_range(0, 32'hffff), 16'h0} | 32'($urandom_range(0, 255) * 4);
                wb_halt  = ($urandom_range(0, 9) == 0);
            end
            tick();
        end
        stall = 1'b0; wb_valid = 1'b0; wb_halt = 1'b0;

        // Three-thread instance: tids 0 and 2 alternate across the wrap
        run3 = 3'b101;
        for (int i = 0; i < 10; i++) begin
            wb3_valid = iv3; wb3_tid = tid3; wb3_pc = pc3 + 32'd4;
            @(posedge clk);
            #1;
            if (iv3) seq3.push_back(int'(tid3));
        end
        wb3_valid = 1'b0;
        chk("n3_len", 64'(seq3.size() >= 8), 64'd1);
        for (int i = 0; i < 8; i++)
            if (i < seq3.size()) chk("n3_order", 64'(seq3[i]), 64'((i % 2 == 0) ? 0 : 2));
        chk("n3_err_clear", 64'(err3), 64'd0);
        wb3_valid = 1'b1; wb3_tid = 2'd3;
        @(posedge clk);
        #1;
        wb3_valid = 1'b0;
        chk("n3_err_oob_tid", 64'(err3), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
